// File: rtl/toggle_rx_pkg.sv
`default_nettype none
// ============================================================================
// toggle_rx_pkg : shared widths and helpers for the toggle_rx_mc receiver
// Rev 1.0
// ============================================================================
package toggle_rx_pkg;

    localparam int unsigned DEF_CNT_W = 4;

    // Pending-event counter at the default width; instances with another
    // CNT_W declare their own logic [CNT_W-1:0] storage.
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Warm-up counter must reach SYNC_STAGES+1.
    function automatic int unsigned warm_w(input int unsigned sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_rx_mc_if.sv
`default_nettype none
// ============================================================================
// toggle_rx_mc_if : toggle inputs plus tagged valid/ready event stream
// Optional: TOGGLE_RX_OVF_EN adds the sticky per-channel ovf vector
// Rev 1.0
// ============================================================================
interface toggle_rx_mc_if
    import toggle_rx_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = ch_w(NUM_CH)
);
    logic [NUM_CH-1:0] tog_in;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [NUM_CH-1:0] pend;
`ifdef TOGGLE_RX_OVF_EN
    logic [NUM_CH-1:0] ovf;
`endif

    modport master (
        input  tog_in, out_ready,
        output out_valid, out_ch, pend
`ifdef TOGGLE_RX_OVF_EN
        , output ovf
`endif
    );

    modport slave (
        output tog_in, out_ready,
        input  out_valid, out_ch, pend
`ifdef TOGGLE_RX_OVF_EN
        , input ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sync_dff.sv
`default_nettype none
// ============================================================================
// sync_dff : DEPTH-stage flop synchroniser, WIDTH independent bits
// Rev 1.0
// ============================================================================
module sync_dff #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '{default: '0};
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/toggle_rx_rr_arb.sv
`default_nettype none
// ============================================================================
// toggle_rx_rr_arb : first requester at or above ptr, wrapping to 0
// Rev 1.0
// ============================================================================
module toggle_rx_rr_arb #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [CH_W-1:0]   ptr,
    output logic      [CH_W-1:0]   grant,
    output logic                   any
);
    int w_off;
    int w_best;

    // Smallest circular distance from ptr wins.
    always_comb begin
        grant  = '0;
        any    = 1'b0;
        w_off  = 0;
        w_best = int'(NUM_CH);
        for (int j = 0; j < NUM_CH; j++) begin
            w_off = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + int'(NUM_CH) - int'(ptr));
            if (req[j] && (w_off < w_best)) begin
                w_best = w_off;
                grant  = CH_W'(j);
                any    = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/toggle_rx_mc.sv
`default_nettype none
// ============================================================================
// toggle_rx_mc : multi-channel toggle-event receiver with round-robin output
// Optional: TOGGLE_RX_OVF_EN adds sticky per-channel overflow flags
// Rev 1.0
// ============================================================================
module toggle_rx_mc
    import toggle_rx_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    toggle_rx_mc_if.master  bus
);
    localparam int unsigned       CH_W       = ch_w(NUM_CH);
    localparam int unsigned       WARM_W     = warm_w(SYNC_STAGES);
    localparam logic [WARM_W-1:0] C_WARM_END = WARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [CH_W-1:0]   C_LAST_CH  = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] r_hist;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_dec;
    logic [NUM_CH-1:0] r_pend;
    logic [CNT_W-1:0]  r_cnt     [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [WARM_W-1:0] r_warm;
    logic              w_warming;
    logic              w_load;
    logic              w_any;
    logic              r_valid;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_ptr;

    sync_dff #(
        .WIDTH (NUM_CH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.tog_in),
        .q     (w_sync)
    );

    // Edges are masked until the synchroniser and history have settled, so
    // levels held through reset never look like toggles.
    assign w_warming = (r_warm != C_WARM_END);
    assign w_edge    = w_warming ? '0 : (w_sync ^ r_hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm <= '0;
            r_hist <= '0;
        end else begin
            r_hist <= w_sync;
            if (w_warming) begin
                r_warm <= r_warm + WARM_W'(1);
            end
        end
    end

    toggle_rx_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req   (r_pend),
        .ptr   (r_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    assign w_load = !r_valid || bus.out_ready;

    always_comb begin
        w_dec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dec[c]     = w_load && w_any && (w_grant == CH_W'(c));
            w_cnt_nxt[c] = r_cnt[c];
            if (w_edge[c] && !w_dec[c]) begin
                if (r_cnt[c] != C_CNT_MAX) begin
                    w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
                end
            end else if (w_dec[c] && !w_edge[c]) begin
                w_cnt_nxt[c] = r_cnt[c] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '{default: '0};
            r_pend <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c]  <= w_cnt_nxt[c];
                r_pend[c] <= (w_cnt_nxt[c] != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_ch  <= w_grant;
                r_ptr <= (w_grant == C_LAST_CH) ? '0 : (w_grant + CH_W'(1));
            end
        end
    end

`ifdef TOGGLE_RX_OVF_EN
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] r_ovf;

    always_comb begin
        w_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_drop[c] = w_edge[c] && !w_dec[c] && (r_cnt[c] == C_CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | w_drop;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.out_valid = r_valid;
    assign bus.out_ch    = r_ch;
    assign bus.pend      = r_pend;
endmodule
`default_nettype wire

// File: tb/tb_toggle_rx_mc.sv
`default_nettype none
// ============================================================================
// tb_toggle_rx_mc : scoreboard bench for toggle_rx_mc (NUM_CH=4, SS=2, CNT_W=4)
// Rev 1.0
// ============================================================================
module tb_toggle_rx_mc;
    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   t_drv  = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   hs_cnt = 0;
    int   sb[$];

    toggle_rx_mc_if #(.NUM_CH(NUM_CH)) bus ();

    toggle_rx_mc #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Every accepted event must match the next expected channel.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            check("hs_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) check("hs_ch", int'(bus.out_ch), sb.pop_front());
        end
    end

    task automatic toggle(input logic [NUM_CH-1:0] m);
        @(posedge clk); #1;
        bus.tog_in = bus.tog_in ^ m;
        t_drv = cyc;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        bus.out_ready = v;
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", int'(bus.out_valid), 1);
    endtask

    task automatic burst(input int n);
        wait_valid(12);
        for (int i = 0; i < n; i++) begin
            check("burst_valid", int'(bus.out_valid), 1);
            @(negedge clk);
        end
        check("burst_end", int'(bus.out_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen, first, nval, hs0;
        rst_n         = 1'b0;
        bus.tog_in    = 4'b0101;
        bus.out_ready = 1'b0;

        // Reset state and warm-up with levels held high through reset
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_ch",    int'(bus.out_ch), 0);
        check("rst_pend",  int'(bus.pend), 0);
`ifdef TOGGLE_RX_OVF_EN
        check("rst_ovf",   int'(bus.ovf), 0);
`endif
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        count_valid(10, seen);
        check("warm_no_evt", seen, 0);
        check("warm_pend",   int'(bus.pend), 0);

        // Single event latency and width
        toggle(4'b0100);
        sb.push_back(2);
        first = -1;
        nval  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (first < 0) first = cyc - t_drv;
                nval++;
            end
        end
        check("latency",   first, 4);
        check("one_cycle", nval, 1);

        // All channels at once from pointer 0, then from pointer 2
        do_reset();
        toggle(4'b1111);
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
        burst(4);
        toggle(4'b0010);
        sb.push_back(1);
        count_valid(8, seen);
        check("single_ch1", seen, 1);
        toggle(4'b1111);
        sb.push_back(2); sb.push_back(3); sb.push_back(0); sb.push_back(1);
        burst(4);

        // Saturation under backpressure: 1 held + 15 counted, 4 dropped
        set_ready(1'b0);
        for (int k = 0; k < 20; k++) begin
            toggle(4'b0010);
            repeat (3) @(posedge clk);
        end
        for (int k = 0; k < 16; k++) sb.push_back(1);
        repeat (4) @(negedge clk);
        check("sat_pend1", int'(bus.pend[1]), 1);
        check("sat_valid", int'(bus.out_valid), 1);
        check("sat_ch",    int'(bus.out_ch), 1);
`ifdef TOGGLE_RX_OVF_EN
        check("ovf_set",   int'(bus.ovf), 2);
`endif
        hs0 = hs_cnt;
        set_ready(1'b1);
        repeat (30) @(negedge clk);
        check("drain_count", hs_cnt - hs0, 16);
        check("drain_sb",    sb.size(), 0);
        check("drain_pend",  int'(bus.pend), 0);
`ifdef TOGGLE_RX_OVF_EN
        check("ovf_sticky",  int'(bus.ovf), 2);
`endif

        // Presented event held stable while another channel arrives
        set_ready(1'b0);
        toggle(4'b1000);
        sb.push_back(3);
        wait_valid(10);
        check("bp_first_ch", int'(bus.out_ch), 3);
        toggle(4'b0001);
        sb.push_back(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_ch",    int'(bus.out_ch), 3);
            check("bp_hold_valid", int'(bus.out_valid), 1);
        end
        check("bp_pend0", int'(bus.pend[0]), 1);
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        check("bp_sb", sb.size(), 0);

        // Reset mid-burst with 6 events outstanding
        set_ready(1'b0);
        toggle(4'b1111);
        repeat (3) @(posedge clk);
        toggle(4'b0011);
        repeat (6) @(negedge clk);
        check("pre_rst_pend",  int'(bus.pend), 15);
        check("pre_rst_valid", int'(bus.out_valid), 1);
        check("pre_rst_ch",    int'(bus.out_ch), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_pend",  int'(bus.pend), 0);
`ifdef TOGGLE_RX_OVF_EN
        check("mid_rst_ovf",   int'(bus.ovf), 0);
`endif
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        count_valid(15, seen);
        check("post_rst_stale", seen, 0);
        check("final_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
